// File: rtl/jram_loader.sv
//------------------------------------------------------------------------------
// jram_loader -- MAR + DATA_W x 2^ADDR_W RAM with a valid/ready program loader
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jram_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int INC_EN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] bas,
  input  logic              sa,
  input  logic [DATA_W-1:0] bis,
  input  logic              s,
  input  logic              e,
  input  logic              inc,
  output logic [DATA_W-1:0] bos,
  output logic [ADDR_W-1:0] mar,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              busy,
  output logic              ld_trunc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              trunc_q, trunc_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    ptr_d   = ptr_q;
    trunc_d = trunc_q;
    we      = 1'b0;
    waddr   = mar_q;
    wdata   = bis;

    case (state_q)
      ST_IDLE: begin
        // The write always targets the pre-edge MAR, even when sa/inc move it.
        we = s;
        if (sa) begin
          mar_d = bas;
        end else if (inc && (INC_EN != 0)) begin
          mar_d = mar_q + ADDR_W'(1);
        end
        if (ld_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          trunc_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          we    = 1'b1;
          waddr = ptr_q;
          wdata = ld_data;
          ptr_d = ptr_q + ADDR_W'(1);
          if (ld_last) begin
            state_d = ST_DONE;
          end else if (ptr_q == {ADDR_W{1'b1}}) begin
            state_d = ST_DONE;
            trunc_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        mar_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      ptr_q   <= '0;
      trunc_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      ptr_q   <= ptr_d;
      trunc_q <= trunc_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Storage is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign bos      = (e && (state_q == ST_IDLE)) ? mem[mar_q] : '0;
  assign mar      = mar_q;
  assign busy     = busy_q;
  assign ld_ready = ready_q;
  assign ld_trunc = trunc_q;

endmodule

`default_nettype wire
